// File: rtl/mul163_d8_ctrl.sv
// Sequencer for a digit-serial GF(2^163) multiplier with 8-bit digits.
// Latches one request, streams B MSB-first, waits out the datapath latency and captures the product.
module mul163_d8_ctrl #(
  parameter int M      = 163,
  parameter int D      = 8,
  parameter int CW     = 5,
  parameter int DP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [M-1:0]  a_in,
  input  logic [M-1:0]  b_in,
  input  logic [M-1:0]  dp_result,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [M-1:0]  a_op,
  output logic [D-1:0]  b_digit,
  output logic [CW-1:0] digit_idx,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [M-1:0]  c_out
);

  localparam int NDIG = (M + D - 1) / D;
  localparam int BW   = NDIG * D;
  localparam int DL   = (DP_LAT > 0) ? DP_LAT - 1 : 0;
  localparam logic [CW-1:0] LAST_DIG   = CW'(NDIG - 1);
  localparam logic [1:0]    DRAIN_LAST = 2'(DL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    a_op_q, a_op_d;
  logic [BW-1:0]   bsr_q, bsr_d;
  logic [CW-1:0]   digit_idx_q, digit_idx_d;
  logic [1:0]      drain_cnt_q, drain_cnt_d;
  logic [M-1:0]    c_out_q, c_out_d;
  logic [D-1:0]    b_digit_q, b_digit_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            acc_clr_q, acc_clr_d;
  logic            acc_en_q, acc_en_d;

  // b_digit is registered, so bsr runs one digit ahead of the digit on the output
  always_comb begin
    state_d     = state_q;
    a_op_d      = a_op_q;
    bsr_d       = bsr_q;
    digit_idx_d = digit_idx_q;
    drain_cnt_d = drain_cnt_q;
    c_out_d     = c_out_q;
    b_digit_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          a_op_d  = a_in;
          bsr_d   = {{(BW-M){1'b0}}, b_in};
        end
      end
      S_LOAD: begin
        digit_idx_d = '0;
        if (abort) begin
          state_d = S_IDLE;
          bsr_d   = '0;
        end else begin
          state_d   = S_RUN;
          b_digit_d = bsr_q[BW-1 -: D];
          bsr_d     = {bsr_q[BW-D-1:0], {D{1'b0}}};
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          bsr_d   = '0;
        end else if (digit_idx_q == LAST_DIG) begin
          if (DP_LAT == 0) begin
            c_out_d = dp_result;
            state_d = S_DONE;
          end else begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end else begin
          digit_idx_d = digit_idx_q + 1'b1;
          b_digit_d   = bsr_q[BW-1 -: D];
          bsr_d       = {bsr_q[BW-D-1:0], {D{1'b0}}};
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          bsr_d   = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          c_out_d = dp_result;
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    acc_clr_d = (state_d == S_LOAD);
    acc_en_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_op_q      <= '0;
      bsr_q       <= '0;
      digit_idx_q <= '0;
      drain_cnt_q <= '0;
      c_out_q     <= '0;
      b_digit_q   <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_op_q      <= a_op_d;
      bsr_q       <= bsr_d;
      digit_idx_q <= digit_idx_d;
      drain_cnt_q <= drain_cnt_d;
      c_out_q     <= c_out_d;
      b_digit_q   <= b_digit_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      acc_clr_q   <= acc_clr_d;
      acc_en_q    <= acc_en_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign a_op      = a_op_q;
  assign b_digit   = b_digit_q;
  assign digit_idx = digit_idx_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_mul163_d8_ctrl.sv
// Bench for mul163_d8_ctrl: three instances (DP_LAT = 1, 0, 3) each driving a behavioural
// digit-serial datapath, checked every cycle against a request-level timing model and a GF(2^163) product.
module tb_mul163_d8_ctrl;

   localparam int M = 163;

   logic          clk = 1'b0;
   logic          rst;
   logic          abort;
   logic [M-1:0]  aIn;
   logic [M-1:0]  bIn;
   logic          startV [3];

   logic          readyV [3];
   logic          busyV [3];
   logic          doneV [3];
   logic          accClrV [3];
   logic          accEnV [3];
   logic [M-1:0]  aOpV [3];
   logic [M-1:0]  cOutV [3];
   logic [M-1:0]  dpRes [3];
   logic [7:0]    bDigitV [3];
   logic [4:0]    idxV [3];

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   // Request-level model state, advanced once per clock edge
   int            cyc = 0;
   bit            active [3];
   int            startCyc [3];
   int            lastIdx [3];
   logic [M-1:0]  opA [3];
   logic [M-1:0]  opB [3];
   logic [M-1:0]  opRes [3];
   logic [M-1:0]  expCout [3];

   always #5 clk = ~clk;

   function automatic int latOf(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
   endfunction

   // One datapath accumulation step: acc*x^8 + a*digit, reduced by x^163+x^7+x^6+x^3+1
   function automatic logic [M-1:0] dpStep(input logic [M-1:0] acc, input logic [M-1:0] a, input logic [7:0] dig);
      logic [M-1:0] t;
      logic msb;
      t = acc;
      for (int j = 7; j >= 0; j--) begin
         msb = t[M-1];
         t = t << 1;
         if (msb) t = t ^ {{(M-8){1'b0}}, 8'hC9};
         if (dig[j]) t = t ^ a;
      end
      return t;
   endfunction

   // Reference product: full carry-less multiply followed by top-down reduction
   function automatic logic [M-1:0] gfMulRef(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [2*M-2:0] p;
      p = '0;
      for (int i = 0; i < M; i++)
         if (b[i]) p = p ^ ({{(M-1){1'b0}}, a} << i);
      for (int i = 2*M-2; i >= M; i--) begin
         if (p[i]) begin
            p[i] = 1'b0;
            p[i-M+7] = ~p[i-M+7];
            p[i-M+6] = ~p[i-M+6];
            p[i-M+3] = ~p[i-M+3];
            p[i-M]   = ~p[i-M];
         end
      end
      return p[M-1:0];
   endfunction

   function automatic logic [7:0] digitOf(input logic [M-1:0] b, input int k);
      logic [167:0] t;
      t = {5'b0, b} >> (8 * (20 - k));
      return t[7:0];
   endfunction

   function automatic int idxAfterAbort(input int r);
      if (r <= 1) return 0;
      if (r <= 22) return r - 2;
      return 20;
   endfunction

   function automatic logic [M-1:0] randWide();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[M-1:0];
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gInst
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      logic [M-1:0] accReg, pipe1, pipe2;

      mul163_d8_ctrl #(.DP_LAT(L)) dut (
         .clk(clk), .rst(rst), .start(startV[g]), .abort(abort),
         .a_in(aIn), .b_in(bIn), .dp_result(dpRes[g]),
         .ready(readyV[g]), .busy(busyV[g]), .done(doneV[g]),
         .a_op(aOpV[g]), .b_digit(bDigitV[g]), .digit_idx(idxV[g]),
         .acc_clr(accClrV[g]), .acc_en(accEnV[g]), .c_out(cOutV[g])
      );

      // Behavioural datapath: registered accumulator plus output delay stages
      always @(posedge clk) begin
         if (accClrV[g]) accReg <= '0;
         else if (accEnV[g]) accReg <= dpStep(accReg, aOpV[g], bDigitV[g]);
         pipe1 <= accReg;
         pipe2 <= pipe1;
      end

      if (L == 0) begin : gLat0
         assign dpRes[g] = accEnV[g] ? dpStep(accReg, aOpV[g], bDigitV[g]) : accReg;
      end else if (L == 1) begin : gLat1
         assign dpRes[g] = accReg;
      end else begin : gLat3
         assign dpRes[g] = pipe2;
      end
   end

   // Model: accept, abort, capture and completion decided from cycles since accept
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            active[i]  <= 1'b0;
            expCout[i] <= '0;
            lastIdx[i] <= 0;
         end else if (active[i]) begin
            if (abort && (cyc - startCyc[i]) <= 22 + latOf(i)) begin
               active[i]  <= 1'b0;
               lastIdx[i] <= idxAfterAbort(cyc - startCyc[i]);
            end else if ((cyc - startCyc[i]) == 22 + latOf(i)) begin
               expCout[i] <= opRes[i];
            end else if ((cyc - startCyc[i]) == 23 + latOf(i)) begin
               active[i]  <= 1'b0;
               lastIdx[i] <= 20;
            end
         end else if (startV[i] && !abort) begin
            active[i]   <= 1'b1;
            startCyc[i] <= cyc;
            opA[i]      <= aIn;
            opB[i]      <= bIn;
            opRes[i]    <= gfMulRef(aIn, bIn);
         end
      end
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   // Compare every instance against the model on each falling edge
   always @(negedge clk) begin
      if (checkEn) begin
         for (int i = 0; i < 3; i++) begin
            int r, L, eIdx;
            bit act, eEn;
            logic [7:0] eDig;
            L = latOf(i);
            act = active[i];
            r = cyc - startCyc[i];
            eEn = act && r >= 2 && r <= 22;
            eDig = eEn ? digitOf(opB[i], r - 2) : 8'h00;
            if (!act || r == 1) eIdx = lastIdx[i];
            else if (r <= 22) eIdx = r - 2;
            else eIdx = 20;
            checkOutput($sformatf("ready%0d", i), M'(readyV[i]), M'(!act));
            checkOutput($sformatf("busy%0d", i), M'(busyV[i]), M'(act && r <= 22 + L));
            checkOutput($sformatf("done%0d", i), M'(doneV[i]), M'(act && r == 23 + L));
            checkOutput($sformatf("accClr%0d", i), M'(accClrV[i]), M'(act && r == 1));
            checkOutput($sformatf("accEn%0d", i), M'(accEnV[i]), M'(eEn));
            checkOutput($sformatf("bDigit%0d", i), M'(bDigitV[i]), M'(eDig));
            checkOutput($sformatf("digitIdx%0d", i), M'(idxV[i]), M'(eIdx));
            checkOutput($sformatf("cOut%0d", i), cOutV[i], expCout[i]);
            if (act) checkOutput($sformatf("aOp%0d", i), aOpV[i], opA[i]);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a falling edge; start is sampled at the next rising edge (cycle 0)
   task automatic applyStimulus(input logic [M-1:0] a, input logic [M-1:0] b, input logic [2:0] mask);
      aIn = a;
      bIn = b;
      for (int i = 0; i < 3; i++) startV[i] = mask[i];
      @(negedge clk);
      for (int i = 0; i < 3; i++) startV[i] = 1'b0;
      aIn = randWide();
      bIn = randWide();
   endtask

   initial begin
      logic [M-1:0] bPat;
      rst = 1'b1;
      abort = 1'b0;
      aIn = '0;
      bIn = '0;
      for (int i = 0; i < 3; i++) begin
         startV[i] = 1'b0;
         active[i] = 1'b0;
         startCyc[i] = 0;
         lastIdx[i] = 0;
         opA[i] = '0;
         opB[i] = '0;
         opRes[i] = '0;
         expCout[i] = '0;
      end
      @(posedge clk);
      @(posedge clk);
      checkEn = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      $display("[TB] basic multiply a=1 b=1");
      applyStimulus(163'h1, 163'h1, 3'b111);
      idle(30);

      $display("[TB] digit order");
      bPat = {3'h7, {19{8'hFF}}, 8'hA5};
      applyStimulus(randWide(), bPat, 3'b111);
      idle(30);

      $display("[TB] start while busy");
      applyStimulus(randWide(), randWide(), 3'b001);
      idle(4);
      startV[0] = 1'b1;
      idle(1);
      startV[0] = 1'b0;
      idle(18);
      startV[0] = 1'b1;
      idle(1);
      applyStimulus(randWide(), randWide(), 3'b001);
      idle(28);

      $display("[TB] abort mid-run");
      applyStimulus(randWide(), randWide(), 3'b111);
      idle(9);
      abort = 1'b1;
      idle(1);
      abort = 1'b0;
      idle(5);

      $display("[TB] start together with abort while idle");
      for (int i = 0; i < 3; i++) startV[i] = 1'b1;
      abort = 1'b1;
      idle(1);
      for (int i = 0; i < 3; i++) startV[i] = 1'b0;
      abort = 1'b0;
      idle(3);

      $display("[TB] reset mid-run");
      applyStimulus(randWide(), randWide(), 3'b111);
      idle(9);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(5);

      $display("[TB] randomized requests");
      for (int n = 0; n < 12; n++) begin
         int abortCyc;
         abortCyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 27)) : -1;
         applyStimulus(randWide(), randWide(), 3'b111);
         for (int c = 1; c <= 28; c++) begin
            abort = (c == abortCyc);
            for (int i = 0; i < 3; i++) startV[i] = ($urandom_range(0, 9) == 0);
            @(negedge clk);
         end
         abort = 1'b0;
         for (int i = 0; i < 3; i++) startV[i] = 1'b0;
         idle(30);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
